int_mul_iter_param: RTL and testbench

INT_MUL_ITER_PARAM -- requirements
Module: int_mul_iter_param

---
 rtl/int_mul_iter_param.sv | 86 ++++++++
 tb/tb_int_mul_iter_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/int_mul_iter_param.sv
// Iterative shift-and-add integer multiplier with a val/rdy request/response handshake.
// Returns the low p_nbits of a*b, retiring one multiplier bit per cycle, with optional early termination.
module int_mul_iter_param #(
    parameter int p_nbits      = 32,
    parameter int p_early_exit = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_val_i,
    output logic                   req_rdy_o,
    input  logic [2*p_nbits-1:0]   req_msg_i,
    output logic                   resp_val_o,
    input  logic                   resp_rdy_i,
    output logic [p_nbits-1:0]     resp_msg_o
);

    localparam int CW = $clog2(p_nbits) + 1;
    localparam logic [CW-1:0] LAST = CW'(p_nbits - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [p_nbits-1:0]   a_q, a_d;
    logic [p_nbits-1:0]   b_q, b_d;
    logic [p_nbits-1:0]   res_q, res_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [p_nbits-1:0]   b_shr;
    logic                 calc_end;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Early exit fires once no set multiplier bits remain after this cycle's shift.
    assign b_shr    = b_q >> 1;
    assign calc_end = (cnt_q == LAST) || ((p_early_exit != 0) && (b_shr == '0));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        req_rdy_o  = 1'b0;
        resp_val_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_rdy_o = 1'b1;
                if (req_val_i) begin
                    a_d     = req_msg_i[2*p_nbits-1:p_nbits];
                    b_d     = req_msg_i[p_nbits-1:0];
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (b_q[0]) res_d = res_q + a_q;
                a_d   = a_q << 1;
                b_d   = b_shr;
                cnt_d = cnt_q + CW'(1);
                if (calc_end) state_d = S_DONE;
            end
            S_DONE: begin
                resp_val_o = 1'b1;
                if (resp_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_msg_o = res_q;

endmodule

// File: tb/tb_int_mul_iter_param.sv
// Scoreboard bench for int_mul_iter_param: three instances (32-bit fixed latency,
// 32-bit early exit, 8-bit early exit) driven by directed and random transactions.
module tb_int_mul_iter_param;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst, req_val, req_rdy, resp_val, resp_rdy;
    logic [63:0]  req_msg [N];
    logic [31:0]  r0, r1;
    logic [7:0]   r2;

    int nb [N] = '{32, 32, 8};
    int ee [N] = '{0, 1, 1};

    typedef struct {
        logic [31:0] prod;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    int_mul_iter_param #(.p_nbits(32), .p_early_exit(0)) dut0 (
        .clk_i(clk), .reset_i(rst[0]), .req_val_i(req_val[0]), .req_rdy_o(req_rdy[0]),
        .req_msg_i(req_msg[0]), .resp_val_o(resp_val[0]), .resp_rdy_i(resp_rdy[0]),
        .resp_msg_o(r0));
    int_mul_iter_param #(.p_nbits(32), .p_early_exit(1)) dut1 (
        .clk_i(clk), .reset_i(rst[1]), .req_val_i(req_val[1]), .req_rdy_o(req_rdy[1]),
        .req_msg_i(req_msg[1]), .resp_val_o(resp_val[1]), .resp_rdy_i(resp_rdy[1]),
        .resp_msg_o(r1));
    int_mul_iter_param #(.p_nbits(8), .p_early_exit(1)) dut2 (
        .clk_i(clk), .reset_i(rst[2]), .req_val_i(req_val[2]), .req_rdy_o(req_rdy[2]),
        .req_msg_i(req_msg[2][15:0]), .resp_val_o(resp_val[2]), .resp_rdy_i(resp_rdy[2]),
        .resp_msg_o(r2));

    function automatic logic [31:0] rmsg(int d);
        case (d)
            0:       return r0;
            1:       return r1;
            default: return {24'h0, r2};
        endcase
    endfunction

    function automatic logic [31:0] model_prod(int d, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return (nb[d] == 32) ? p[31:0] : {24'h0, p[7:0]};
    endfunction

    // Cycles from accept to first resp_val: CALC cycles plus one.
    function automatic int model_lat(int d, logic [31:0] b);
        int m;
        if (ee[d] == 0) return nb[d] + 1;
        m = 0;
        for (int i = 0; i < nb[d]; i++) if (b[i]) m = i + 1;
        return ((m == 0) ? 1 : m) + 1;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn(int d, logic [31:0] a, logic [31:0] b, int stall);
        int          cyc;
        exp_t        e;
        logic [31:0] held;
        cyc = 0;
        while (!req_rdy[d] && cyc < 50) begin step(); cyc++; end
        chk($sformatf("d%0d req_rdy before accept", d), 64'(req_rdy[d]), 64'd1);
        e.prod = model_prod(d, a, b);
        e.lat  = model_lat(d, b);
        sbq.push_back(e);
        req_val[d] = 1'b1;
        req_msg[d] = (nb[d] == 32) ? {a, b} : {48'h0, a[7:0], b[7:0]};
        step();
        req_val[d] = 1'b0;
        req_msg[d] = 64'hA5A5_5A5A_F0F0_0F0F;
        cyc = 1;
        chk($sformatf("d%0d busy req_rdy", d), 64'(req_rdy[d]), 64'd0);
        resp_rdy[d] = 1'b0;
        while (!resp_val[d] && cyc < 100) begin step(); cyc++; end
        e = sbq.pop_front();
        chk($sformatf("d%0d latency a=%0h b=%0h", d, a, b), 64'(cyc), 64'(e.lat));
        chk($sformatf("d%0d product a=%0h b=%0h", d, a, b), 64'(rmsg(d)), 64'(e.prod));
        held = rmsg(d);
        for (int s = 0; s < stall; s++) begin
            step();
            chk($sformatf("d%0d stall resp_val", d), 64'(resp_val[d]), 64'd1);
            chk($sformatf("d%0d stall resp_msg", d), 64'(rmsg(d)), 64'(held));
            chk($sformatf("d%0d stall req_rdy", d), 64'(req_rdy[d]), 64'd0);
        end
        resp_rdy[d] = 1'b1;
        step();
        chk($sformatf("d%0d idle req_rdy", d), 64'(req_rdy[d]), 64'd1);
        chk($sformatf("d%0d idle resp_val", d), 64'(resp_val[d]), 64'd0);
    endtask

    initial begin
        int seen;
        rst      = '1;
        req_val  = '0;
        resp_rdy = '1;
        for (int i = 0; i < N; i++) req_msg[i] = 64'h0;
        req_val[0] = 1'b1;
        req_msg[0] = {32'd5, 32'd5};
        @(negedge clk);
        step();
        step();
        rst     = '0;
        req_val = '0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("d%0d reset req_rdy", i), 64'(req_rdy[i]), 64'd1);
            chk($sformatf("d%0d reset resp_val", i), 64'(resp_val[i]), 64'd0);
            chk($sformatf("d%0d reset resp_msg", i), 64'(rmsg(i)), 64'd0);
        end

        // 32-bit, fixed latency
        txn(0, 32'd3, 32'd4, 0);
        txn(0, 32'hFFFF_FFFD, 32'd5, 0);
        txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

        // Abort mid-CALC: reset in cycle 5 after accept
        req_val[0] = 1'b1;
        req_msg[0] = {32'd3, 32'd4};
        step();
        req_val[0] = 1'b0;
        repeat (4) step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk("d0 abort req_rdy", 64'(req_rdy[0]), 64'd1);
        chk("d0 abort resp_val", 64'(resp_val[0]), 64'd0);
        chk("d0 abort resp_msg", 64'(rmsg(0)), 64'd0);
        seen = 0;
        repeat (40) begin step(); if (resp_val[0]) seen++; end
        chk("d0 abort no response", 64'(seen), 64'd0);
        txn(0, 32'd6, 32'd7, 0);

        // 32-bit, early exit
        txn(1, 32'd7, 32'd5, 0);
        txn(1, 32'd9, 32'd0, 0);
        txn(1, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        txn(1, 32'hFFFF_FFFD, 32'd5, 1);
        for (int k = 0; k < 4; k++)
            txn(1, $urandom, $urandom >> $urandom_range(0, 31), $urandom_range(0, 3));

        // 8-bit, early exit: truncation then back-to-back
        txn(2, 32'h10, 32'h20, 0);
        txn(2, 32'd2, 32'd3, 0);
        for (int k = 0; k < 4; k++)
            txn(2, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));

        chk("scoreboard drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
